// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register with ALU op decode and operand forwarding for the 5-stage MIPS datapath.
// Define FORWARD_EN to enable the EX/MEM and MEM/WB forwarding muxes; otherwise operands come straight from the register.
module estagio_id_ex #(
    parameter int LARGURA   = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valido,
    input  logic [LARGURA-1:0]   id_dado1,
    input  logic [LARGURA-1:0]   id_dado2,
    input  logic [LARGURA-1:0]   id_imediato,
    input  logic [NREG_BITS-1:0] id_rs,
    input  logic [NREG_BITS-1:0] id_rt,
    input  logic [NREG_BITS-1:0] id_rd,
    input  logic                 id_usa_imediato,
    input  logic                 id_reg_dest,
    input  logic                 id_escreve_reg,
    input  logic [1:0]           id_aluop,
    input  logic [5:0]           id_funct,
    input  logic                 exmem_escreve,
    input  logic                 memwb_escreve,
    input  logic [NREG_BITS-1:0] exmem_reg,
    input  logic [NREG_BITS-1:0] memwb_reg,
    input  logic [LARGURA-1:0]   exmem_resultado,
    input  logic [LARGURA-1:0]   memwb_resultado,
    output logic                 ex_valido,
    output logic [LARGURA-1:0]   entrada1,
    output logic [LARGURA-1:0]   entrada2,
    output logic [3:0]           unidadeControle,
    output logic [LARGURA-1:0]   ex_dado_store,
    output logic [NREG_BITS-1:0] ex_reg_destino,
    output logic                 ex_escreve_reg,
    output logic                 ex_funct_ilegal
);

`ifdef FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // id_valido qualifies the ID inputs and ex_valido qualifies this stage; stall is the only backpressure.
    logic                 valido_q, valido_d;
    logic [LARGURA-1:0]   dado1_q, dado1_d;
    logic [LARGURA-1:0]   dado2_q, dado2_d;
    logic [LARGURA-1:0]   imediato_q, imediato_d;
    logic [NREG_BITS-1:0] rs_q, rs_d;
    logic [NREG_BITS-1:0] rt_q, rt_d;
    logic [NREG_BITS-1:0] destino_q, destino_d;
    logic                 usa_imediato_q, usa_imediato_d;
    logic                 escreve_q, escreve_d;
    logic [3:0]           codigo_q, codigo_d;
    logic                 ilegal_q, ilegal_d;

    logic [3:0]           codigo_dec;
    logic                 ilegal_dec;
    logic [LARGURA-1:0]   op_a, op_b;

    always_comb begin
        codigo_dec = 4'd2;
        ilegal_dec = 1'b0;
        case (id_aluop)
            2'b00: codigo_dec = 4'd2;
            2'b01: codigo_dec = 4'd3;
            2'b11: codigo_dec = 4'd1;
            default: begin
                case (id_funct)
                    6'b100100: codigo_dec = 4'd0;
                    6'b100101: codigo_dec = 4'd1;
                    6'b100000: codigo_dec = 4'd2;
                    6'b100010: codigo_dec = 4'd3;
                    6'b101010: codigo_dec = 4'd4;
                    6'b100111: codigo_dec = 4'd5;
                    default:   ilegal_dec = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        valido_d       = valido_q;
        dado1_d        = dado1_q;
        dado2_d        = dado2_q;
        imediato_d     = imediato_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        destino_d      = destino_q;
        usa_imediato_d = usa_imediato_q;
        escreve_d      = escreve_q;
        codigo_d       = codigo_q;
        ilegal_d       = ilegal_q;
        if (flush) begin
            valido_d       = 1'b0;
            dado1_d        = '0;
            dado2_d        = '0;
            imediato_d     = '0;
            rs_d           = '0;
            rt_d           = '0;
            destino_d      = '0;
            usa_imediato_d = 1'b0;
            escreve_d      = 1'b0;
            codigo_d       = '0;
            ilegal_d       = 1'b0;
        end else if (!stall) begin
            valido_d       = id_valido;
            dado1_d        = id_dado1;
            dado2_d        = id_dado2;
            imediato_d     = id_imediato;
            rs_d           = id_rs;
            rt_d           = id_rt;
            destino_d      = id_reg_dest ? id_rd : id_rt;
            usa_imediato_d = id_usa_imediato;
            escreve_d      = id_escreve_reg & id_valido;
            codigo_d       = codigo_dec;
            ilegal_d       = ilegal_dec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valido_q       <= 1'b0;
            dado1_q        <= '0;
            dado2_q        <= '0;
            imediato_q     <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            destino_q      <= '0;
            usa_imediato_q <= 1'b0;
            escreve_q      <= 1'b0;
            codigo_q       <= '0;
            ilegal_q       <= 1'b0;
        end else begin
            valido_q       <= valido_d;
            dado1_q        <= dado1_d;
            dado2_q        <= dado2_d;
            imediato_q     <= imediato_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            destino_q      <= destino_d;
            usa_imediato_q <= usa_imediato_d;
            escreve_q      <= escreve_d;
            codigo_q       <= codigo_d;
            ilegal_q       <= ilegal_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins when both match; r0 is hardwired and never forwarded.
    always_comb begin
        op_a = dado1_q;
        op_b = dado2_q;
        if (FWD_EN && exmem_escreve && exmem_reg != '0 && exmem_reg == rs_q)
            op_a = exmem_resultado;
        else if (FWD_EN && memwb_escreve && memwb_reg != '0 && memwb_reg == rs_q)
            op_a = memwb_resultado;
        if (FWD_EN && exmem_escreve && exmem_reg != '0 && exmem_reg == rt_q)
            op_b = exmem_resultado;
        else if (FWD_EN && memwb_escreve && memwb_reg != '0 && memwb_reg == rt_q)
            op_b = memwb_resultado;
    end

    assign ex_valido       = valido_q;
    assign entrada1        = op_a;
    assign entrada2        = usa_imediato_q ? imediato_q : op_b;
    assign ex_dado_store   = op_b;
    assign unidadeControle = codigo_q;
    assign ex_reg_destino  = destino_q;
    assign ex_escreve_reg  = escreve_q;
    assign ex_funct_ilegal = ilegal_q;

endmodule

// File: tb/tb_estagio_id_ex.sv
// Directed bench for estagio_id_ex: driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_estagio_id_ex;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [3:0]  uc;
        logic [31:0] st;
        logic [4:0]  dst;
        logic        wr;
        logic        il;
    } exp_t;

    logic        clock, reset, stall, flush;
    logic        id_valido, id_usa_imediato, id_reg_dest, id_escreve_reg;
    logic [31:0] id_dado1, id_dado2, id_imediato;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        exmem_escreve, memwb_escreve;
    logic [4:0]  exmem_reg, memwb_reg;
    logic [31:0] exmem_resultado, memwb_resultado;
    logic        ex_valido, ex_escreve_reg, ex_funct_ilegal;
    logic [31:0] entrada1, entrada2, ex_dado_store;
    logic [3:0]  unidadeControle;
    logic [4:0]  ex_reg_destino;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    estagio_id_ex dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .id_valido(id_valido), .id_dado1(id_dado1), .id_dado2(id_dado2),
        .id_imediato(id_imediato), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_usa_imediato(id_usa_imediato), .id_reg_dest(id_reg_dest),
        .id_escreve_reg(id_escreve_reg), .id_aluop(id_aluop), .id_funct(id_funct),
        .exmem_escreve(exmem_escreve), .memwb_escreve(memwb_escreve),
        .exmem_reg(exmem_reg), .memwb_reg(memwb_reg),
        .exmem_resultado(exmem_resultado), .memwb_resultado(memwb_resultado),
        .ex_valido(ex_valido), .entrada1(entrada1), .entrada2(entrada2),
        .unidadeControle(unidadeControle), .ex_dado_store(ex_dado_store),
        .ex_reg_destino(ex_reg_destino), .ex_escreve_reg(ex_escreve_reg),
        .ex_funct_ilegal(ex_funct_ilegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic drive_id(input logic vld, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic ui, input logic rdst,
                            input logic wr, input logic [1:0] aop, input logic [5:0] fn);
        id_valido = vld; id_dado1 = d1; id_dado2 = d2; id_imediato = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_usa_imediato = ui;
        id_reg_dest = rdst; id_escreve_reg = wr; id_aluop = aop; id_funct = fn;
    endtask

    task automatic set_fwd(input logic exw, input logic [4:0] exr, input logic [31:0] exv,
                           input logic mww, input logic [4:0] mwr, input logic [31:0] mwv);
        exmem_escreve = exw; exmem_reg = exr; exmem_resultado = exv;
        memwb_escreve = mww; memwb_reg = mwr; memwb_resultado = mwv;
    endtask

    task automatic fwd_none();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input logic v, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [3:0] uc, input logic [31:0] st, input logic [4:0] dst,
                              input logic wr, input logic il);
        exp_t e;
        e.v = v; e.e1 = e1; e.e2 = e2; e.uc = uc; e.st = st; e.dst = dst; e.wr = wr; e.il = il;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ex_valido",       {31'b0, ex_valido},       {31'b0, e.v});
            chk("entrada1",        entrada1,                 e.e1);
            chk("entrada2",        entrada2,                 e.e2);
            chk("unidadeControle", {28'b0, unidadeControle}, {28'b0, e.uc});
            chk("ex_dado_store",   ex_dado_store,            e.st);
            chk("ex_reg_destino",  {27'b0, ex_reg_destino},  {27'b0, e.dst});
            chk("ex_escreve_reg",  {31'b0, ex_escreve_reg},  {31'b0, e.wr});
            chk("ex_funct_ilegal", {31'b0, ex_funct_ilegal}, {31'b0, e.il});
        end
    end

    logic [5:0] fn_tab [3];
    logic [3:0] uc_tab [3];

    initial begin
        fn_tab[0] = 6'b100101; uc_tab[0] = 4'd1;
        fn_tab[1] = 6'b101010; uc_tab[1] = 4'd4;
        fn_tab[2] = 6'b100111; uc_tab[2] = 4'd5;

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_id(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 2'b10, 6'b100010);
        set_fwd(1'b1, 5'd7, 32'h99, 1'b1, 5'd8, 32'h98);
        tick(); fwd_none(); expect_out(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); expect_out(0, 0, 0, 0, 0, 0, 0, 0);

        // plain add, rd destination
        reset = 1'b0;
        drive_id(1, 32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 2'b10, 6'b100000);
        tick(); fwd_none(); expect_out(1, 32'd5, 32'd7, 4'd2, 32'd7, 5'd3, 1, 0);

        // sub, both producers hit rs: EX/MEM wins
        drive_id(1, 32'h11, 32'h22, 0, 5'd4, 5'd6, 5'd0, 0, 0, 1, 2'b10, 6'b100010);
        tick(); set_fwd(1, 5'd4, 32'hAA, 1, 5'd4, 32'hBB);
        expect_out(1, FWD ? 32'hAA : 32'h11, 32'h22, 4'd3, 32'h22, 5'd6, 1, 0);

        // rs=0 never forwarded; rt hits MEM/WB only
        drive_id(1, 32'h33, 32'h44, 0, 5'd0, 5'd9, 5'd12, 0, 1, 1, 2'b10, 6'b100100);
        tick(); set_fwd(1, 5'd0, 32'hCC, 1, 5'd9, 32'hBB);
        expect_out(1, 32'h33, FWD ? 32'hBB : 32'h44, 4'd0, FWD ? 32'hBB : 32'h44, 5'd12, 1, 0);

        // EX/MEM matches but does not write, MEM/WB takes over; aluop 11 -> or
        drive_id(1, 32'h101, 32'h202, 0, 5'd5, 5'd5, 5'd0, 0, 0, 1, 2'b11, 6'b000000);
        tick(); set_fwd(0, 5'd5, 32'hEE, 1, 5'd5, 32'hFF);
        expect_out(1, FWD ? 32'hFF : 32'h101, FWD ? 32'hFF : 32'h202, 4'd1,
                   FWD ? 32'hFF : 32'h202, 5'd5, 1, 0);

        // immediate operand; store data still forwarded
        drive_id(1, 32'h66, 32'h55, 32'hFFFF_FFFC, 5'd8, 5'd7, 5'd0, 1, 0, 1, 2'b00, 6'b000000);
        tick(); set_fwd(1, 5'd7, 32'h77, 0, 5'd0, 32'h0);
        expect_out(1, 32'h66, 32'hFFFF_FFFC, 4'd2, FWD ? 32'h77 : 32'h55, 5'd7, 1, 0);

        // aluop 01 ignores funct
        drive_id(1, 32'd9, 32'd4, 0, 5'd10, 5'd11, 5'd12, 0, 1, 1, 2'b01, 6'b111111);
        tick(); fwd_none(); expect_out(1, 32'd9, 32'd4, 4'd3, 32'd4, 5'd12, 1, 0);

        for (int i = 0; i < 3; i++) begin
            drive_id(1, 32'h1000 + i, 32'h2000 + i, 0, 5'd1, 5'd2, 5'(3 + i), 0, 1, 1, 2'b10, fn_tab[i]);
            tick(); fwd_none();
            expect_out(1, 32'h1000 + i, 32'h2000 + i, uc_tab[i], 32'h2000 + i, 5'(3 + i), 1, 0);
        end

        // invalid instruction: write enable gated
        drive_id(0, 32'h71, 32'h72, 0, 5'd1, 5'd2, 5'd13, 0, 1, 1, 2'b10, 6'b100000);
        tick(); fwd_none(); expect_out(0, 32'h71, 32'h72, 4'd2, 32'h72, 5'd13, 0, 0);

        // stall for 3 cycles while ID keeps changing
        drive_id(1, 32'hA1, 32'hA2, 32'h5, 5'd3, 5'd4, 5'd14, 1, 1, 1, 2'b10, 6'b101010);
        tick(); expect_out(1, 32'hA1, 32'h5, 4'd4, 32'hA2, 5'd14, 1, 0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_id(1, 32'hB0 + k, 32'hC0 + k, 32'hD0, 5'd20, 5'd21, 5'd22, 0, 1, 1, 2'b00, 6'b0);
            tick(); expect_out(1, 32'hA1, 32'h5, 4'd4, 32'hA2, 5'd14, 1, 0);
        end

        // flush beats stall
        flush = 1'b1;
        tick(); expect_out(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0; stall = 1'b0;

        drive_id(1, 32'h3, 32'h4, 0, 5'd1, 5'd2, 5'd5, 0, 1, 1, 2'b10, 6'b000000);
        tick(); expect_out(1, 32'h3, 32'h4, 4'd2, 32'h4, 5'd5, 1, 1);
        drive_id(1, 32'h8, 32'h9, 0, 5'd1, 5'd2, 5'd6, 0, 1, 1, 2'b10, 6'b100000);
        tick(); expect_out(1, 32'h8, 32'h9, 4'd2, 32'h9, 5'd6, 1, 0);

        // flush alone, then reset beats a pending load
        flush = 1'b1;
        tick(); expect_out(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
        tick(); expect_out(1, 32'h8, 32'h9, 4'd2, 32'h9, 5'd6, 1, 0);
        reset = 1'b1;
        tick(); expect_out(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clock);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/estagio_id_ex.md
Name: estagio_id_ex

Overview:
- ID/EX pipeline register and operand-selection stage of the 5-stage MIPS datapath; sits directly upstream of the ALU.
- Each cycle it captures decoded operands and control from ID.
- It resolves the 4-bit ALU operation code and forwards EX/MEM or MEM/WB results onto the ALU operands.
- Its outputs drive the ALU inputs entrada1, entrada2 and unidadeControle.

Parameters:
- LARGURA, 32, data path width.
- NREG_BITS, 5, register index width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold stage contents.
- flush  input  1  load a bubble.
- id_valido  input  1  ID carries a valid instruction.
- id_dado1  input  LARGURA  register file read of rs.
- id_dado2  input  LARGURA  register file read of rt.
- id_imediato  input  LARGURA  sign-extended immediate.
- id_rs, id_rt, id_rd  input  NREG_BITS each  register indices.
- id_usa_imediato  input  1  ALUSrc.
- id_reg_dest  input  1  1 selects rd as destination, 0 selects rt.
- id_escreve_reg  input  1  RegWrite.
- id_aluop  input  2  00 add, 01 sub, 10 decode funct, 11 or.
- id_funct  input  6  R-type funct field.
- exmem_escreve, memwb_escreve  input  1  producer writes a register.
- exmem_reg, memwb_reg  input  NREG_BITS  producer destination.
- exmem_resultado, memwb_resultado  input  LARGURA  producer value.
- ex_valido  output  1  stage holds a valid instruction.
- entrada1, entrada2  output  LARGURA  ALU operands.
- unidadeControle  output  4  ALU operation code.
- ex_dado_store  output  LARGURA  forwarded rt value, for sw.
- ex_reg_destino  output  NREG_BITS  write-back register.
- ex_escreve_reg  output  1  RegWrite, gated by valid.
- ex_funct_ilegal  output  1  unknown funct was captured.

Behaviour:
- Registered state: valido, dado1, dado2, imediato, rs, rt, destino, usa_imediato, escreve, codigo[3:0], ilegal.
- Reset: all state is 0. Outputs after reset are: ex_valido=0, ex_escreve_reg=0, unidadeControle=0, ex_funct_ilegal=0, ex_reg_destino=0, entrada1=0 and entrada2=0 (with no forwarding hit).
- Priority per rising edge: reset > flush > stall > load.
  - Flush: state is cleared exactly as on reset (bubble).
  - Stall without flush: all state holds.
  - Load: all state captures the ID inputs; valido=id_valido; escreve=id_escreve_reg & id_valido.
- Latency: exactly one cycle from ID inputs to the registered outputs.
- Destination: destino = id_reg_dest ? id_rd : id_rt.
- Operation code, decoded at capture:
  - aluop 00 -> 2; 01 -> 3; 11 -> 1.
  - aluop 10 with funct 100100 -> 0, 100101 -> 1, 100000 -> 2, 100010 -> 3, 101010 -> 4, 100111 -> 5.
  - Any other funct -> code 2 and ilegal=1. ilegal is 0 in every other case.
- Forwarding is combinational on the current-cycle producer inputs, applied per operand (rs -> A, rt -> B):
  - If exmem_escreve, exmem_reg != 0 and exmem_reg == index -> exmem_resultado.
  - Else if the same conditions hold for memwb -> memwb_resultado.
  - Else the registered value.
  - EX/MEM beats MEM/WB on a simultaneous match.
  - Register 0 is never forwarded.
- Operand outputs: entrada1 = A; entrada2 = usa_imediato ? imediato : B; ex_dado_store = B in all cases.
- Bubble: forwarding still computes, but because ex_escreve_reg=0 the downstream write has no effect.

Optional Feature:
- Macro: FORWARD_EN.
- Defined: forwarding muxes as above.
- Undefined: A = registered dado1 and B = registered dado2. Forwarding inputs remain as ports but are ignored; hazards are then resolved by stall insertion upstream.

Test Plan:
- Reset high for 2 cycles with arbitrary inputs -> all outputs 0 and unidadeControle=0.
- Load add: aluop 10, funct 100000, dado1=5, dado2=7, rd=3, reg_dest=1 -> next cycle entrada1=5, entrada2=7, unidadeControle=2, ex_reg_destino=3, ex_escreve_reg=1.
- Simultaneous hazard: rs=4 with exmem_reg=4 (value 0xAA) and memwb_reg=4 (value 0xBB), both writes set -> entrada1=0xAA. Same case with rs=0 -> entrada1=registered dado1.
- Load with id_usa_imediato=1, imediato=0xFFFFFFFC, aluop 00 -> entrada2=0xFFFFFFFC, unidadeControle=2, ex_dado_store=forwarded rt.
- Stall and flush:
  - Stall for 3 cycles while ID changes -> outputs frozen.
  - Flush asserted together with stall -> next cycle ex_valido=0 and ex_escreve_reg=0.
- Illegal funct: funct 000000 with aluop 10 -> unidadeControle=2 and ex_funct_ilegal=1. The next legal load clears it.
